// File: rtl/jtkicker_obj_pkg.sv
// Shared constants for the Kicker object RAM: entry byte offsets, attr bits, scan states.
package jtkicker_obj_pkg;

   localparam int unsigned OFS_ATTR = 0;
   localparam int unsigned OFS_CODE = 1;
   localparam int unsigned OFS_X    = 0;
   localparam int unsigned OFS_Y    = 1;

   localparam int unsigned ATTR_VFLIP = 7;
   localparam int unsigned ATTR_HFLIP = 6;
   localparam int unsigned ATTR_CODE8 = 5;

   localparam int unsigned OBJ_LIMIT = 24;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StAddrE = 3'd1,
      StAddrO = 3'd2,
      StCmp   = 3'd3,
      StEmit  = 3'd4
   } scan_state_e;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Two-port synchronous RAM, single clock, read-before-write on both ports.
module jtframe_dual_ram #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 8
)(
   input  logic          clk,
   input  logic [DW-1:0] data0,
   input  logic [AW-1:0] addr0,
   input  logic          we0,
   output logic [DW-1:0] q0,
   input  logic [DW-1:0] data1,
   input  logic [AW-1:0] addr1,
   input  logic          we1,
   output logic [DW-1:0] q1
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we0) mem[addr0] <= data0;
      if (we1) mem[addr1] <= data1;
      q0 <= mem[addr0];
      q1 <= mem[addr1];
   end

endmodule

// File: rtl/jtkicker_obj_scan.sv
// Per-line sprite table scanner with valid/ready descriptor output.
// JTKICKER_OBJ_LIMIT_EN caps accepted descriptors per line at OBJ_LIMIT.
module jtkicker_obj_scan
   import jtkicker_obj_pkg::*;
#(
   parameter int unsigned ENTRIES = 32,
   parameter int unsigned OBJ_H   = 16
)(
   input  logic       clk,
   input  logic       rstn,
   input  logic       hs,
   input  logic       flip,
   input  logic [7:0] vrender,
   output logic [7:0] ram_addr,
   input  logic [7:0] ram1_q,
   input  logic [7:0] ram2_q,
   output logic       draw_valid,
   input  logic       draw_ready,
   output logic [8:0] draw_code,
   output logic [3:0] draw_pal,
   output logic       draw_hflip,
   output logic [7:0] draw_x,
   output logic [3:0] draw_ysub,
   output logic       scan_busy
);

   localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   scan_state_e   state_q, state_d, next_st;
   logic [IW-1:0] idx_q, idx_d, next_idx;
   logic [7:0]    line_q, line_d, attr_q, attr_d, x_q, x_d, d;
   logic          hs_q, hs_rise, last_idx, match, load;
   logic          unused_attr;
`ifdef JTKICKER_OBJ_LIMIT_EN
   logic [4:0]    cnt_q, cnt_d;
`endif

   assign hs_rise     = hs & ~hs_q;
   assign last_idx    = (idx_q == IW'(ENTRIES - 1));
   assign d           = line_q - ram2_q;
   assign match       = (ram2_q != 8'd0) && (32'(d) < OBJ_H);
   assign ram_addr    = 8'({idx_q, (state_q == StAddrO) ? 1'(OFS_CODE) : 1'(OFS_ATTR)});
   // A new line aborts a pending descriptor before it can be accepted
   assign draw_valid  = (state_q == StEmit) & ~hs_rise;
   assign scan_busy   = (state_q != StIdle);
   assign unused_attr = attr_q[4];

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      line_d   = line_q;
      attr_d   = attr_q;
      x_d      = x_q;
      load     = 1'b0;
      next_st  = last_idx ? StIdle : StAddrE;
      next_idx = last_idx ? idx_q : idx_q + 1'b1;
`ifdef JTKICKER_OBJ_LIMIT_EN
      cnt_d    = cnt_q;
`endif
      if (hs_rise) begin
         state_d = StAddrE;
         idx_d   = '0;
         line_d  = vrender ^ {8{flip}};
`ifdef JTKICKER_OBJ_LIMIT_EN
         cnt_d   = '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StIdle;
            end
            StAddrE: begin
               state_d = StAddrO;
            end
            StAddrO: begin
               attr_d  = ram1_q;
               x_d     = ram2_q;
               state_d = StCmp;
            end
            StCmp: begin
               if (match) begin
                  load    = 1'b1;
                  state_d = StEmit;
               end else begin
                  state_d = next_st;
                  idx_d   = next_idx;
               end
            end
            StEmit: begin
               if (draw_ready) begin
                  state_d = next_st;
                  idx_d   = next_idx;
`ifdef JTKICKER_OBJ_LIMIT_EN
                  cnt_d   = cnt_q + 1'b1;
                  if (cnt_q == 5'(OBJ_LIMIT - 1)) state_d = StIdle;
`endif
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         line_q     <= '0;
         attr_q     <= '0;
         x_q        <= '0;
         hs_q       <= 1'b0;
         draw_code  <= '0;
         draw_pal   <= '0;
         draw_hflip <= 1'b0;
         draw_x     <= '0;
         draw_ysub  <= '0;
`ifdef JTKICKER_OBJ_LIMIT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         line_q  <= line_d;
         attr_q  <= attr_d;
         x_q     <= x_d;
         hs_q    <= hs;
`ifdef JTKICKER_OBJ_LIMIT_EN
         cnt_q   <= cnt_d;
`endif
         if (load) begin
            draw_code  <= {attr_q[ATTR_CODE8], ram1_q};
            draw_pal   <= attr_q[3:0];
            draw_hflip <= attr_q[ATTR_HFLIP];
            draw_x     <= x_q;
            draw_ysub  <= d[3:0] ^ {4{attr_q[ATTR_VFLIP]}};
         end
      end
   end

endmodule

// File: rtl/jtkicker_objram.sv
// Kicker object RAM: two CPU-visible 256-byte banks plus the line scanner.
// JTKICKER_OBJ_LIMIT_EN enables the per-line sprite limit inside the scanner.
module jtkicker_objram
   import jtkicker_obj_pkg::*;
#(
   parameter int unsigned ENTRIES = 32,
   parameter int unsigned OBJ_H   = 16
)(
   input  logic       clk,
   input  logic       rstn,
   input  logic       cpu_cen,
   input  logic       obj1_cs,
   input  logic       obj2_cs,
   input  logic       cpu_rnw,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_dout,
   output logic [7:0] obj_dout,
   input  logic       flip,
   input  logic       hs,
   input  logic [7:0] vrender,
   output logic       draw_valid,
   input  logic       draw_ready,
   output logic [8:0] draw_code,
   output logic [3:0] draw_pal,
   output logic       draw_hflip,
   output logic [7:0] draw_x,
   output logic [3:0] draw_ysub,
   output logic       scan_busy
);

   logic       we1, we2, sel1_q, sel2_q;
   logic [7:0] cpu_q1, cpu_q2, scan_q1, scan_q2, scan_addr, hold_q;

   assign we1 = cpu_cen & obj1_cs & ~cpu_rnw;
   assign we2 = cpu_cen & obj2_cs & ~cpu_rnw;

   jtframe_dual_ram #(.DW(8), .AW(8)) u_bank1 (
      .clk   (clk),
      .data0 (cpu_dout),
      .addr0 (cpu_addr),
      .we0   (we1),
      .q0    (cpu_q1),
      .data1 (8'd0),
      .addr1 (scan_addr),
      .we1   (1'b0),
      .q1    (scan_q1)
   );

   jtframe_dual_ram #(.DW(8), .AW(8)) u_bank2 (
      .clk   (clk),
      .data0 (cpu_dout),
      .addr0 (cpu_addr),
      .we0   (we2),
      .q0    (cpu_q2),
      .data1 (8'd0),
      .addr1 (scan_addr),
      .we1   (1'b0),
      .q1    (scan_q2)
   );

   // RAM output is already the registered read; the mux picks it or holds the last byte
   always_comb begin
      obj_dout = hold_q;
      if (sel1_q)      obj_dout = cpu_q1;
      else if (sel2_q) obj_dout = cpu_q2;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sel1_q <= 1'b0;
         sel2_q <= 1'b0;
         hold_q <= '0;
      end else begin
         sel1_q <= obj1_cs;
         sel2_q <= obj2_cs & ~obj1_cs;
         hold_q <= obj_dout;
      end
   end

   jtkicker_obj_scan #(.ENTRIES(ENTRIES), .OBJ_H(OBJ_H)) u_scan (
      .clk        (clk),
      .rstn       (rstn),
      .hs         (hs),
      .flip       (flip),
      .vrender    (vrender),
      .ram_addr   (scan_addr),
      .ram1_q     (scan_q1),
      .ram2_q     (scan_q2),
      .draw_valid (draw_valid),
      .draw_ready (draw_ready),
      .draw_code  (draw_code),
      .draw_pal   (draw_pal),
      .draw_hflip (draw_hflip),
      .draw_x     (draw_x),
      .draw_ysub  (draw_ysub),
      .scan_busy  (scan_busy)
   );

endmodule

// File: doc/jtkicker_objram.md
# jtkicker_objram

Object RAM responder and per-line sprite scanner for the Kicker main board. It answers the main CPU's `obj1_cs`/`obj2_cs` bus accesses, where the CPU is the bus initiator. It stores both 256-byte object banks. On every line it walks the sprite table and hands matching entries to the object line-buffer drawer over a valid/ready handshake.

## Interface
Parameters:
- `ENTRIES`, 32: sprites scanned per line, each entry occupying 2 bytes in each bank.
- `OBJ_H`, 16: sprite height in lines; must be a power of two.

Ports:
- `clk` in 1: 24 MHz system clock.
- `rstn` in 1: reset. One clock; reset is asynchronous and active-low.
- `cpu_cen` in 1: CPU Q clock enable.
- `obj1_cs` in 1: CPU selects bank 1 (attr/code).
- `obj2_cs` in 1: CPU selects bank 2 (x/y).
- `cpu_rnw` in 1: 1 = read.
- `cpu_addr` in 8: CPU A[7:0]. Upper bits are mirrored.
- `cpu_dout` in 8: CPU write data.
- `obj_dout` out 8: read data to the CPU mux.
- `flip` in 1: screen flip.
- `hs` in 1: horizontal sync. A rising edge starts a scan.
- `vrender` in 8: line being prepared.
- `draw_valid` out 1: a sprite descriptor is presented.
- `draw_ready` in 1: the drawer accepts the descriptor.
- `draw_code` out 9: sprite tile code.
- `draw_pal` out 4: sprite palette.
- `draw_hflip` out 1: horizontal flip.
- `draw_x` out 8: horizontal position.
- `draw_ysub` out 4: row within the sprite, with vflip already applied.
- `scan_busy` out 1: high while the scanner is not IDLE.

## Operation
- **Entry layout:**
  - Bank 1: `[2n]` = attr (b7 vflip, b6 hflip, b5 code[8], b3:0 pal), `[2n+1]` = code[7:0].
  - Bank 2: `[2n]` = x, `[2n+1]` = y.
  - Entry n lives at addresses 2n and 2n+1 for n < `ENTRIES`.
  - Bytes above 2·`ENTRIES` are plain storage, readable and writable by the CPU.
- **CPU writes:** take effect on a clk edge with `cpu_cen & objX_cs & !cpu_rnw`. One byte is written per qualified cen.
- **CPU reads:** `obj_dout` is registered from the selected bank each clk. When both cs are low it holds its last value.
- **Scan FSM states:** IDLE → ADDR_E → ADDR_O → CMP → EMIT → (next entry: ADDR_E, or IDLE).
  - Latching: a rising `hs` latches `line = vrender ^ {8{flip}}` and sets the index to 0.
  - Fetch: ADDR_E presents address 2n to both banks; ADDR_O captures attr/x and presents 2n+1.
  - CMP: captures code/y and computes `d = line - y` (8-bit, wraps modulo 256). The entry matches when `d < OBJ_H` and `y != 0`. An entry with y = 0 is disabled.
  - Match handling: on a match the FSM loads the draw fields and enters EMIT. With no match it moves on to the next index.
  - `draw_ysub`: equals `d[3:0] ^ {4{vflip}}`.
  - EMIT: holds `draw_valid` high until a clk with `draw_ready` high, then advances.
  - End: after index `ENTRIES`-1 the FSM returns to IDLE.
- **Handshake rules:**
  - All draw fields stay stable while `draw_valid` is high and `draw_ready` is low.
  - Exactly one descriptor is transferred per valid&ready clk.
- **Rising `hs` while not IDLE:** aborts the current scan and drops `draw_valid` in the same clk. The un-accepted descriptor is discarded. The scan restarts from index 0 with the new line.
- **Simultaneous CPU write and scan read of the same address:** the scan gets the old data. The write still lands.

## Timing
- All outputs are 0 at reset. The FSM resets to IDLE and `scan_busy` resets to 0.
- CPU read latency is 1 clk from cs/address to `obj_dout`. This is well inside one CPU cen period.
- Scan cost is 3 clk per non-matching entry. A matching entry costs 3 clk plus its EMIT wait, minimum 1 clk.
- Worst case with `draw_ready` tied high is 4·`ENTRIES` = 128 clk, well under one line.
- `hs` edge detection uses a registered copy of `hs`. The scan starts in ADDR_E 1 clk after the edge is seen.

## Configuration
- `JTKICKER_OBJ_LIMIT_EN` defined: a per-line match counter stops the scan (returns to IDLE) after 24 accepted descriptors. This mimics the hardware sprite limit.
- Not defined: every entry is scanned and there is no limit.

## Structure
- Package `jtkicker_obj_pkg` holds:
  - the entry byte offsets;
  - the attr bit positions;
  - the FSM state encodings;
  - `OBJ_LIMIT` = 24.
- Each bank is a `jtframe_dual_ram` instance. Port 0 serves the CPU and port 1 serves the scanner.
- Sub-module `jtkicker_obj_scan` holds the FSM, the compare logic and the handshake. The top level holds the RAMs and the CPU mux.

## Test plan
- **CPU round trip:** write 0xA5 to bank 1 address 0x10 and 0x3C to bank 2 address 0x11, then read both back → `obj_dout` returns 0xA5 and 0x3C one clk after cs.
- **Basic match:** entry 3 = {attr 0x25, code 0x40, x 0x80, y 0x50}, `vrender` = 0x55, `flip` = 0, `hs` edge → exactly one descriptor: code 0x140, pal 5, x 0x80, ysub 5, hflip 0.
- **vflip and wrap:** attr 0x80, y 0xF8, `vrender` 0x02 → d = 10, ysub = 5. With `vrender` 0x08 → no match.
- **Backpressure and abort:** hold `draw_ready` low → fields stay stable. Issue a new `hs` edge → `draw_valid` falls in the same clk and the scan restarts at index 0.
- **Limit on:** with the macro defined and all 32 entries matching → 24 descriptors and `scan_busy` falls. With the macro undefined → 32 descriptors.
- **Reset mid-scan:** assert `rstn` low during EMIT → `draw_valid` is 0 and `scan_busy` is 0 immediately. RAM contents are unchanged.
